// File: rtl/tt_check_pkg.sv
// Shared types and constants for truth-table sweep stages.
// Row r = {in1,in2,in3}; the expected output for row r lives at bit 7-r.
package tt_check_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    SAMPLE,
    DONE
  } tt_state_e;

  localparam int         NUM_ROWS = 8;
  localparam logic [7:0] TT_0XD4  = 8'hD4;

  function automatic logic tt_expected(input logic [7:0] tt, input logic [2:0] row);
    return tt[3'd7 - row];
  endfunction

endpackage

// File: rtl/tt_settle_timer.sv
// Loadable up-counter with a terminal-count flag at SETTLE_CYCLES-1.
// Load clears the count and takes priority over the enable.
module tt_settle_timer #(
  parameter int SETTLE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic en,
  output logic tc
);

  localparam logic [7:0] TC_VALUE = 8'(SETTLE_CYCLES - 1);

  logic [7:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= 8'd0;
    end else if (load) begin
      count <= 8'd0;
    end else if (en) begin
      count <= count + 8'd1;
    end
  end

  assign tc = (count == TC_VALUE);

endmodule

// File: rtl/tt_sweep_checker.sv
// Drives all eight input rows into a 3-input netlist, samples its output after
// a settle time and compares the observed truth table against TRUTH_TABLE.
module tt_sweep_checker
  import tt_check_pkg::*;
#(
  parameter logic [7:0] TRUTH_TABLE   = TT_0XD4,
  parameter int         SETTLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       abort,
  input  logic       dut_out,
  output logic       in1,
  output logic       in2,
  output logic       in3,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [7:0] result,
  output logic [3:0] mismatch_cnt
);

  tt_state_e  state_q, state_d;
  logic [2:0] row_q;
  logic [2:0] drive_q;
  logic       timer_load, timer_en, timer_tc;
  logic       accept, abort_hit, sample_en;
  logic       last_row;
  logic [3:0] mismatch_next;

  assign last_row      = (row_q == 3'(NUM_ROWS - 1));
  assign mismatch_next = mismatch_cnt + 4'(dut_out != tt_expected(TRUTH_TABLE, row_q));

  tt_settle_timer #(
    .SETTLE_CYCLES(SETTLE_CYCLES)
  ) u_timer (
    .clk  (clk),
    .rst_n(rst_n),
    .load (timer_load),
    .en   (timer_en),
    .tc   (timer_tc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Abort is checked before any SAMPLE update so a cancelled row is never recorded.
  always_comb begin
    state_d    = state_q;
    timer_load = 1'b0;
    timer_en   = 1'b0;
    accept     = 1'b0;
    abort_hit  = 1'b0;
    sample_en  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          accept     = 1'b1;
          timer_load = 1'b1;
          state_d    = SETTLE;
        end
      end
      SETTLE: begin
        if (abort) begin
          abort_hit  = 1'b1;
          timer_load = 1'b1;
          state_d    = IDLE;
        end else begin
          timer_en = 1'b1;
          if (timer_tc) state_d = SAMPLE;
        end
      end
      SAMPLE: begin
        if (abort) begin
          abort_hit  = 1'b1;
          timer_load = 1'b1;
          state_d    = IDLE;
        end else begin
          sample_en = 1'b1;
          if (last_row) begin
            state_d = DONE;
          end else begin
            timer_load = 1'b1;
            state_d    = SETTLE;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Pass is resolved together with the last sample so it is valid during DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_q        <= 3'd0;
      drive_q      <= 3'd0;
      result       <= 8'd0;
      mismatch_cnt <= 4'd0;
      pass         <= 1'b0;
    end else if (accept) begin
      row_q        <= 3'd0;
      drive_q      <= 3'd0;
      result       <= 8'd0;
      mismatch_cnt <= 4'd0;
      pass         <= 1'b0;
    end else if (abort_hit) begin
      drive_q <= 3'd0;
      pass    <= 1'b0;
    end else if (sample_en) begin
      result[3'd7 - row_q] <= dut_out;
      mismatch_cnt         <= mismatch_next;
      if (last_row) begin
        pass <= (mismatch_next == 4'd0);
      end else begin
        row_q   <= row_q + 3'd1;
        drive_q <= row_q + 3'd1;
      end
    end
  end

  assign in1  = drive_q[2];
  assign in2  = drive_q[1];
  assign in3  = drive_q[0];
  assign busy = (state_q != IDLE);
  assign done = (state_q == DONE);

endmodule
